wb_unit: RTL and testbench
==========================

# wb_unit

Writeback stage of the NPC pipeline. It accepts completed instructions from the memory stage over a valid/ready handshake, holds them in a one-entry writeback register, formats load data, and drives the register file write port (`wen`/`waddr`/`wdata`). It also keeps the per-register busy scoreboard that stalls decode on RAW/WAW hazards, and counts retired instructions.

## Interface

No parameters.

- `clock`  in  1  single clock for all state
- `reset`  in  1  asynchronous, active-high reset
- `ms_valid`  in  1  memory stage presents an instruction
- `ms_ready`  out  1  writeback register can accept this cycle
- `ms_pc`  in  64  PC of the presented instruction
- `ms_rf_we`  in  1  instruction writes a GPR
- `ms_rd`  in  5  destination register
- `ms_result`  in  64  ALU result, or raw 64-bit load lane data
- `ms_ld`  in  1  instruction is a load; `ms_result` needs formatting
- `ms_ld_size`  in  2  0=byte, 1=half, 2=word, 3=dword
- `ms_ld_unsigned`  in  1  zero-extend, not sign-extend
- `ms_ld_off`  in  3  byte offset of the access within the 64-bit lane
- `halt`  in  1  freezes retirement (difftest/ebreak hold)
- `rf_wen`  out  1  register file write enable
- `rf_waddr`  out  5  register file write address
- `rf_wdata`  out  64  register file write data
- `id_valid`  in  1  decode holds an instruction
- `id_issue`  in  1  decode issues this cycle; only honoured when `id_stall`=0
- `id_rs1`, `id_rs2`  in  5 each  source registers
- `id_rd_we`  in  1  issued instruction will write `id_rd`
- `id_rd`  in  5  destination of the issuing instruction
- `id_stall`  out  1  hazard; decode must not issue
- `commit_valid`  out  1  an instruction retires this cycle
- `commit_pc`  out  64  PC of the retiring instruction
- `instret`  out  64  retired-instruction count

## Operation

- State: `wb_valid`, `wb_pc`, `wb_rf_we`, `wb_rd`, `wb_data`[63:0], `busy`[31:0], `instret`.
- `wb_fire = wb_valid & ~halt`. `ms_ready = ~wb_valid | ~halt`. Transfer occurs when `ms_valid & ms_ready`.
- On transfer, register the instruction. `wb_data` is the load-formatted value when `ms_ld`=1, otherwise `ms_result`.
- Load formatting selects the lane from `ms_result`:
  - byte: `[8*off +: 8]`
  - half: `[16*off[2:1] +: 16]`
  - word: `[32*off[2] +: 32]`
  - dword: the whole value
- Low offset bits below the access size are ignored. Extend to 64 bits with sign or zero per `ms_ld_unsigned`. A dword ignores `ms_ld_unsigned`.
- If `wb_fire` occurs with no transfer, `wb_valid` drops to 0.
- Writeback outputs: `rf_wen = wb_fire & wb_rf_we & (wb_rd != 0)`. `rf_waddr = wb_rd`. `rf_wdata = wb_data`.
- Commit outputs: `commit_valid = wb_fire`. `commit_pc = wb_pc`. `instret` increments by 1 on each `wb_fire` and wraps modulo 2^64.
- Scoreboard:
  - `id_stall = id_valid & (busy[id_rs1] | busy[id_rs2] | (id_rd_we & busy[id_rd]))`.
  - `busy[0]` is hard-wired to 0.
  - Set `busy[id_rd]` on `id_issue & ~id_stall & id_rd_we & id_rd != 0`.
  - Clear `busy[wb_rd]` on `rf_wen`.
  - Set and clear of the same register in the same cycle: set wins.
- No bypass: a register being written this cycle still reads busy this cycle.

## Timing

- Reset (async, immediate) forces the following, and remains in force until the first clock edge after deassertion:
  - `wb_valid`=0, so `ms_ready`=1, `rf_wen`=0, `commit_valid`=0.
  - `busy`=0, so `id_stall`=0.
  - `instret`=0.
- Reset mid-operation discards the held instruction with no write and no commit.
- Latency: transfer at edge E. Then `rf_wen`/`commit_valid` are high in cycle E..E+1 if `halt`=0. The register file and `busy` update at edge E+1. A dependent instruction can issue in the cycle after E+1 and reads the new value.
- Throughput: 1 instruction/cycle. A full register with `halt`=0 accepts a new instruction in the same cycle it retires.
- `halt`=1 holds `wb_*` and `instret` stable and suppresses `rf_wen`. `ms_ready`=0 only when `wb_valid`=1.
- All outputs except the `wb_*`-derived write data are combinational from registered state plus `halt`/`id_*`. The combinational path `id_*` → `id_stall` is allowed.

## Test plan

- Reset, then `ms_valid`=1, rd=5, `ms_rf_we`=1, result=0x1234, no halt → one cycle later `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `commit_valid`=1, `instret`=1.
- Load formatting, each with result=0x8070_6050_4030_2010:
  - byte, off=7, signed → `rf_wdata`=0xFFFF_FFFF_FFFF_FF80
  - half, off=6, unsigned → 0x8070
  - word, off=4, signed → 0xFFFF_FFFF_8070_6050
- Scoreboard: issue rd=3 → next cycle `id_rs1`=3 with `id_valid` gives `id_stall`=1. Stall holds until the edge at which x3 retires, then drops. Issue rd=0 → never stalls.
- Simultaneous events: x7 retires while a new rd=7 issues in the same cycle → `busy[7]` remains 1 afterwards.
- Halt: assert `halt` with the register full → `ms_ready`=0, `rf_wen`=0, `instret` frozen for N cycles. Release → one retire and an immediate accept in that same cycle.
- Async reset mid-flight while `wb_valid`=1 and `busy`=0x88 → all outputs drop immediately with no clock edge, and no write or commit follows.

Source files
------------

// File: rtl/wb_unit_if.sv
// Writeback-stage bus: memory-stage handshake, register-file write port,
// decode scoreboard query and commit/trace outputs.
interface wb_unit_if;
  // Memory stage -> writeback
  logic        ms_valid;
  logic        ms_ready;
  logic [63:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rd;
  logic [63:0] ms_result;
  logic        ms_ld;
  logic [1:0]  ms_ld_size;
  logic        ms_ld_unsigned;
  logic [2:0]  ms_ld_off;
  logic        halt;

  // Register file write port
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  // Decode scoreboard interface
  logic        id_valid;
  logic        id_issue;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rd_we;
  logic [4:0]  id_rd;
  logic        id_stall;

  // Retirement
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] instret;

  // Driving side (pipeline / environment)
  modport master (
    output ms_valid, ms_pc, ms_rf_we, ms_rd, ms_result, ms_ld, ms_ld_size,
           ms_ld_unsigned, ms_ld_off, halt,
           id_valid, id_issue, id_rs1, id_rs2, id_rd_we, id_rd,
    input  ms_ready, rf_wen, rf_waddr, rf_wdata, id_stall,
           commit_valid, commit_pc, instret
  );

  // Writeback unit side
  modport slave (
    input  ms_valid, ms_pc, ms_rf_we, ms_rd, ms_result, ms_ld, ms_ld_size,
           ms_ld_unsigned, ms_ld_off, halt,
           id_valid, id_issue, id_rs1, id_rs2, id_rd_we, id_rd,
    output ms_ready, rf_wen, rf_waddr, rf_wdata, id_stall,
           commit_valid, commit_pc, instret
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: one-entry writeback register with load formatting,
// register-file write port, RAW/WAW busy scoreboard and retire counter.
module wb_unit (
  input  logic      clock,
  input  logic      reset,
  wb_unit_if.slave  bus
);

  logic        wb_valid_q, wb_valid_d;
  logic [63:0] wb_pc_q,    wb_pc_d;
  logic        wb_rf_we_q, wb_rf_we_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [63:0] wb_data_q,  wb_data_d;
  logic [31:0] busy_q,     busy_d;
  logic [63:0] instret_q,  instret_d;

  logic        wb_fire;
  logic        transfer;
  logic        rf_wen;
  logic        id_stall;
  logic        sb_set;
  logic [63:0] ld_data;

  // Handshake, retire and hazard decode from registered state
  always_comb begin
    wb_fire  = wb_valid_q & ~bus.halt;
    transfer = bus.ms_valid & (~wb_valid_q | ~bus.halt);
    rf_wen   = wb_fire & wb_rf_we_q & (wb_rd_q != 5'd0);
    id_stall = bus.id_valid & (busy_q[bus.id_rs1] | busy_q[bus.id_rs2] |
                               (bus.id_rd_we & busy_q[bus.id_rd]));
    sb_set   = bus.id_issue & ~id_stall & bus.id_rd_we & (bus.id_rd != 5'd0);
  end

  assign bus.ms_ready     = ~wb_valid_q | ~bus.halt;
  assign bus.rf_wen       = rf_wen;
  assign bus.rf_waddr     = wb_rd_q;
  assign bus.rf_wdata     = wb_data_q;
  assign bus.id_stall     = id_stall;
  assign bus.commit_valid = wb_fire;
  assign bus.commit_pc    = wb_pc_q;
  assign bus.instret      = instret_q;

  // Load lane selection and sign/zero extension; offset bits below the
  // access size drop out of the part-select base.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic        sx;
    b  = bus.ms_result[{bus.ms_ld_off, 3'b000} +: 8];
    h  = bus.ms_result[{bus.ms_ld_off[2:1], 4'b0000} +: 16];
    w  = bus.ms_result[{bus.ms_ld_off[2], 5'b00000} +: 32];
    sx = ~bus.ms_ld_unsigned;
    unique case (bus.ms_ld_size)
      2'd0:    ld_data = {{56{sx & b[7]}}, b};
      2'd1:    ld_data = {{48{sx & h[15]}}, h};
      2'd2:    ld_data = {{32{sx & w[31]}}, w};
      default: ld_data = bus.ms_result;
    endcase
  end

  // Next-state for the writeback register, scoreboard and retire counter
  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through this block leaves a variable unassigned (which would infer a latch).
    wb_valid_d = wb_valid_q;
    wb_pc_d    = wb_pc_q;
    wb_rf_we_d = wb_rf_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    busy_d     = busy_q;
    instret_d  = instret_q + {63'd0, wb_fire};

    if (transfer) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = bus.ms_pc;
      wb_rf_we_d = bus.ms_rf_we;
      wb_rd_d    = bus.ms_rd;
      wb_data_d  = bus.ms_ld ? ld_data : bus.ms_result;
    end else if (wb_fire) begin
      wb_valid_d = 1'b0;
    end

    // Clear first so a same-cycle set of the same register wins.
    if (rf_wen) busy_d[wb_rd_q] = 1'b0;
    if (sb_set) busy_d[bus.id_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards any held instruction and all busy bits
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the busy vector is a flop array, not a RAM, so it is reset here
    // along with the control state; nothing stale may stall decode after reset.
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_rf_we_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      busy_q     <= '0;
      instret_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_rf_we_q <= wb_rf_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      instret_q  <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: load-format vector table, hand-written
// hazard/halt/reset sequences and a randomized run against a reference model.
module tb_wb_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_unit_if bus ();

  wb_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid;
  logic [63:0] m_pc;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          m_busy [32];
  logic [63:0] m_instret;

  typedef struct {
    logic [63:0] result;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [63:0] expect_data;
  } ld_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load formatting computed arithmetically: shift the aligned lane down,
  // mask to the access width, then sign-fill above it.
  function automatic logic [63:0] ref_fmt(logic [63:0] r, logic [1:0] sz, logic uns, logic [2:0] off);
    int nbytes = 1 << sz;
    int start  = int'(off) & ~(nbytes - 1);
    logic [63:0] v, mask;
    if (sz == 2'd3) return r;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = (r >> (8 * start)) & mask;
    if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = '0; m_we = 0; m_rd = '0; m_data = '0; m_instret = '0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic idle();
    bus.ms_valid = 0; bus.ms_pc = '0; bus.ms_rf_we = 0; bus.ms_rd = '0;
    bus.ms_result = '0; bus.ms_ld = 0; bus.ms_ld_size = '0; bus.ms_ld_unsigned = 0;
    bus.ms_ld_off = '0; bus.halt = 0;
    bus.id_valid = 0; bus.id_issue = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rd_we = 0; bus.id_rd = '0;
  endtask

  task automatic send(input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] res);
    bus.ms_valid = 1; bus.ms_rf_we = 1; bus.ms_rd = rd; bus.ms_pc = pc;
    bus.ms_result = res; bus.ms_ld = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.id_valid = 1; bus.id_issue = 1; bus.id_rd_we = 1; bus.id_rd = rd;
    bus.id_rs1 = '0; bus.id_rs2 = '0;
  endtask

  // Inputs are already driven (just after a falling edge). Compare all
  // outputs with the model, advance the model, cross the rising edge and
  // return at the next falling edge.
  task automatic step();
    logic fire, ready, xfer, wen, stall;
    #1;
    fire  = m_valid & ~bus.halt;
    ready = ~m_valid | ~bus.halt;
    xfer  = bus.ms_valid & ready;
    wen   = fire & m_we & (m_rd != 0);
    stall = bus.id_valid & (m_busy[bus.id_rs1] | m_busy[bus.id_rs2] |
                            (bus.id_rd_we & m_busy[bus.id_rd]));
    check("ms_ready", 64'(bus.ms_ready), 64'(ready));
    check("rf_wen", 64'(bus.rf_wen), 64'(wen));
    if (wen) begin
      check("rf_waddr", 64'(bus.rf_waddr), 64'(m_rd));
      check("rf_wdata", bus.rf_wdata, m_data);
    end
    check("commit_valid", 64'(bus.commit_valid), 64'(fire));
    if (fire) check("commit_pc", bus.commit_pc, m_pc);
    check("instret", bus.instret, m_instret);
    check("id_stall", 64'(bus.id_stall), 64'(stall));

    if (wen) m_busy[m_rd] = 0;
    if (bus.id_issue && !stall && bus.id_rd_we && bus.id_rd != 0) m_busy[bus.id_rd] = 1;
    if (fire) m_instret = m_instret + 64'd1;
    if (xfer) begin
      m_valid = 1; m_pc = bus.ms_pc; m_we = bus.ms_rf_we; m_rd = bus.ms_rd;
      m_data  = bus.ms_ld ? ref_fmt(bus.ms_result, bus.ms_ld_size, bus.ms_ld_unsigned, bus.ms_ld_off)
                          : bus.ms_result;
    end else if (fire) begin
      m_valid = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  ld_vec_t vecs [12];
  logic [63:0] frozen;

  initial begin
    vecs[0]  = '{64'h8070_6050_4030_2010, 2'd0, 1'b0, 3'd7, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{64'h8070_6050_4030_2010, 2'd1, 1'b1, 3'd6, 64'h0000_0000_0000_8070};
    vecs[2]  = '{64'h8070_6050_4030_2010, 2'd2, 1'b0, 3'd4, 64'hFFFF_FFFF_8070_6050};
    vecs[3]  = '{64'h8070_6050_4030_2010, 2'd0, 1'b1, 3'd0, 64'h0000_0000_0000_0010};
    vecs[4]  = '{64'h8070_6050_4030_2010, 2'd1, 1'b0, 3'd3, 64'h0000_0000_0000_4030};
    vecs[5]  = '{64'h8070_6050_4030_2010, 2'd2, 1'b1, 3'd5, 64'h0000_0000_8070_6050};
    vecs[6]  = '{64'h8070_6050_4030_2010, 2'd3, 1'b1, 3'd5, 64'h8070_6050_4030_2010};
    vecs[7]  = '{64'hFEDC_BA98_7654_3210, 2'd0, 1'b0, 3'd6, 64'hFFFF_FFFF_FFFF_FFDC};
    vecs[8]  = '{64'hFEDC_BA98_7654_3210, 2'd1, 1'b0, 3'd7, 64'hFFFF_FFFF_FFFF_FEDC};
    vecs[9]  = '{64'hFEDC_BA98_7654_3210, 2'd2, 1'b0, 3'd0, 64'h0000_0000_7654_3210};
    vecs[10] = '{64'hFEDC_BA98_7654_3210, 2'd2, 1'b1, 3'd6, 64'h0000_0000_FEDC_BA98};
    vecs[11] = '{64'hFEDC_BA98_7654_3210, 2'd3, 1'b0, 3'd0, 64'hFEDC_BA98_7654_3210};

    // Reset state, checked before any clock edge
    reset = 1'b1;
    idle();
    model_reset();
    bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7;
    #1;
    check("rst ms_ready", 64'(bus.ms_ready), 64'd1);
    check("rst rf_wen", 64'(bus.rf_wen), 64'd0);
    check("rst commit_valid", 64'(bus.commit_valid), 64'd0);
    check("rst id_stall", 64'(bus.id_stall), 64'd0);
    check("rst instret", bus.instret, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    idle();

    // Basic write: rd=5, result 0x1234
    send(5'd5, 64'h8000_0000, 64'h1234);
    step();
    idle();
    #1;
    check("basic rf_wen", 64'(bus.rf_wen), 64'd1);
    check("basic rf_waddr", 64'(bus.rf_waddr), 64'd5);
    check("basic rf_wdata", bus.rf_wdata, 64'h1234);
    check("basic commit_valid", 64'(bus.commit_valid), 64'd1);
    step();
    check("basic instret", bus.instret, 64'd1);

    // Load-format vector table
    for (int i = 0; i < 12; i++) begin
      idle();
      send(5'(i + 1), 64'(i * 4), vecs[i].result);
      bus.ms_ld = 1; bus.ms_ld_size = vecs[i].size;
      bus.ms_ld_unsigned = vecs[i].uns; bus.ms_ld_off = vecs[i].off;
      step();
      idle();
      #1;
      check($sformatf("ld_vec%0d rf_wdata", i), bus.rf_wdata, vecs[i].expect_data);
      step();
    end

    // Scoreboard: issue rd=3, dependent stalls until x3 retires
    idle(); issue(5'd3); step();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5'd3;
    #1 check("raw stall set", 64'(bus.id_stall), 64'd1);
    send(5'd3, 64'h100, 64'hABCD); step();
    bus.ms_valid = 0;
    #1 check("raw stall at retire", 64'(bus.id_stall), 64'd1);
    step();
    #1 check("raw stall cleared", 64'(bus.id_stall), 64'd0);
    issue(5'd0); step();
    idle(); bus.id_valid = 1; bus.id_rd_we = 1;
    #1 check("x0 never busy", 64'(bus.id_stall), 64'd0);
    step();

    // Same-cycle retire of x7 and new issue of rd=7: set wins
    idle(); send(5'd7, 64'h200, 64'h77); step();
    idle(); issue(5'd7);
    #1 check("x7 retiring", 64'(bus.rf_wen), 64'd1);
    step();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5'd7;
    #1 check("x7 busy after set/clear", 64'(bus.id_stall), 64'd1);
    step();

    // Halt with the register full, then release
    idle(); send(5'd9, 64'h300, 64'h99); step();
    frozen = m_instret;
    send(5'd10, 64'h304, 64'hAA); bus.halt = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt ms_ready", 64'(bus.ms_ready), 64'd0);
      check("halt rf_wen", 64'(bus.rf_wen), 64'd0);
      check("halt instret", bus.instret, frozen);
      step();
    end
    bus.halt = 0;
    #1;
    check("release rf_waddr", 64'(bus.rf_waddr), 64'd9);
    check("release ms_ready", 64'(bus.ms_ready), 64'd1);
    step();
    idle();
    #1 check("accepted during retire", bus.rf_wdata, 64'hAA);
    step();

    // Async reset mid-flight with busy = 0x88
    idle(); model_reset();
    reset = 1'b1; #2; reset = 1'b0;
    @(negedge clock);
    issue(5'd3); step();
    issue(5'd7); step();
    idle(); send(5'd11, 64'h400, 64'h1); bus.halt = 1; step();
    idle(); bus.halt = 1; send(5'd12, 64'h408, 64'h2); step();
    bus.ms_valid = 0;
    bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7;
    #2;
    check("pre-reset stall", 64'(bus.id_stall), 64'd1);
    reset = 1'b1;
    #1;
    check("async ms_ready", 64'(bus.ms_ready), 64'd1);
    check("async rf_wen", 64'(bus.rf_wen), 64'd0);
    check("async commit_valid", 64'(bus.commit_valid), 64'd0);
    check("async id_stall", 64'(bus.id_stall), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.halt = 0;
    step();
    check("post-reset commit", 64'(bus.commit_valid), 64'd0);

    // Randomized run against the reference model
    for (int n = 0; n < 1500; n++) begin
      bus.ms_valid       = 1'($urandom_range(0, 1));
      bus.ms_pc          = {$urandom, $urandom};
      bus.ms_rf_we       = ($urandom_range(0, 3) != 0);
      bus.ms_rd          = 5'($urandom_range(0, 7));
      bus.ms_result      = {$urandom, $urandom};
      bus.ms_ld          = 1'($urandom_range(0, 1));
      bus.ms_ld_size     = 2'($urandom_range(0, 3));
      bus.ms_ld_unsigned = 1'($urandom_range(0, 1));
      bus.ms_ld_off      = 3'($urandom_range(0, 7));
      bus.halt           = ($urandom_range(0, 4) == 0);
      bus.id_valid       = 1'($urandom_range(0, 1));
      bus.id_issue       = 1'($urandom_range(0, 1));
      bus.id_rs1         = 5'($urandom_range(0, 7));
      bus.id_rs2         = 5'($urandom_range(0, 7));
      bus.id_rd_we       = 1'($urandom_range(0, 1));
      bus.id_rd          = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
